// File: rtl/fp_minmax_prep.sv
// Operand preparation and issue FIFO ahead of the floating-point max/min unit:
// NaN-box check, 10-bit classification and sign/magnitude extension per operand.
module fp_minmax_prep #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_data1,
    input  logic [63:0]              in_data2,
    input  logic [1:0]               in_fmt,
    input  logic [2:0]               in_rm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data1,
    output logic [63:0]              out_data2,
    output logic [64:0]              out_ext1,
    output logic [64:0]              out_ext2,
    output logic [9:0]               out_class1,
    output logic [9:0]               out_class2,
    output logic [1:0]               out_fmt,
    output logic [2:0]               out_rm,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [63:0] data;
        logic [64:0] ext;
        logic [9:0]  cls;
    } prep_t;

    typedef struct packed {
        prep_t       op1;
        prep_t       op2;
        logic [1:0]  fmt;
        logic [2:0]  rm;
    } entry_t;

    function automatic prep_t prepare(input logic [63:0] raw, input logic is_single);
        prep_t p;
        logic [63:0] d;
        logic s, e_ones, e_zero, m_zero, m_msb;
        logic nan, inf, zero, sub, norm;
        d = (is_single && raw[63:32] != 32'hFFFF_FFFF) ? 64'h0000_0000_7FC0_0000 : raw;
        if (is_single) begin
            s      = d[31];
            e_ones = &d[30:23];
            e_zero = ~|d[30:23];
            m_zero = ~|d[22:0];
            m_msb  = d[22];
            p.ext  = {s, 33'b0, d[30:0]};
        end else begin
            s      = d[63];
            e_ones = &d[62:52];
            e_zero = ~|d[62:52];
            m_zero = ~|d[51:0];
            m_msb  = d[51];
            p.ext  = {s, 1'b0, d[62:0]};
        end
        nan  = e_ones & ~m_zero;
        inf  = e_ones & m_zero;
        zero = e_zero & m_zero;
        sub  = e_zero & ~m_zero;
        norm = ~e_ones & ~e_zero;
        // bit 9 down to bit 0: qNaN, sNaN, +inf, +norm, +sub, +0, -0, -sub, -norm, -inf
        p.cls  = {nan & m_msb, nan & ~m_msb, inf & ~s, norm & ~s, sub & ~s,
                  zero & ~s, zero & s, sub & s, norm & s, inf & s};
        p.data = d;
        return p;
    endfunction

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    always_comb begin
        wr_entry     = '0;
        wr_entry.op1 = prepare(in_data1, in_fmt == 2'd0);
        wr_entry.op2 = prepare(in_data2, in_fmt == 2'd0);
        wr_entry.fmt = in_fmt;
        wr_entry.rm  = in_rm;
    end

    assign in_ready  = count < CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_ready && out_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Empty FIFO presents an all-zero head so stale entries never leak downstream.
    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign out_data1  = head.op1.data;
    assign out_data2  = head.op2.data;
    assign out_ext1   = head.op1.ext;
    assign out_ext2   = head.op2.ext;
    assign out_class1 = head.op1.cls;
    assign out_class2 = head.op2.cls;
    assign out_fmt    = head.fmt;
    assign out_rm     = head.rm;

endmodule

// File: tb/tb_fp_minmax_prep.sv
// Self-checking bench for fp_minmax_prep: directed vector table, hand sequences
// and random traffic checked against a queue-based reference model.
module tb_fp_minmax_prep;

    localparam int DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [63:0]            in_data1;
    logic [63:0]            in_data2;
    logic [1:0]             in_fmt;
    logic [2:0]             in_rm;
    logic                   out_valid;
    logic                   out_ready;
    logic [63:0]            out_data1;
    logic [63:0]            out_data2;
    logic [64:0]            out_ext1;
    logic [64:0]            out_ext2;
    logic [9:0]             out_class1;
    logic [9:0]             out_class2;
    logic [1:0]             out_fmt;
    logic [2:0]             out_rm;
    logic [$clog2(DEPTH):0] count;

    fp_minmax_prep #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data1(in_data1), .in_data2(in_data2),
        .in_fmt(in_fmt), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data1(out_data1), .out_data2(out_data2),
        .out_ext1(out_ext1), .out_ext2(out_ext2),
        .out_class1(out_class1), .out_class2(out_class2),
        .out_fmt(out_fmt), .out_rm(out_rm),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [64:0] ext1;
        logic [64:0] ext2;
        logic [9:0]  cls1;
        logic [9:0]  cls2;
        logic [1:0]  fmt;
        logic [2:0]  rm;
    } exp_t;

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
        logic [1:0]  fmt;
        logic [63:0] data1;
        logic [9:0]  cls1;
        logic [9:0]  cls2;
        logic [64:0] ext1;
        logic [64:0] ext2;
    } vec_t;

    exp_t q[$];
    vec_t vecs[5];
    int   nCompared   = 0;
    int   nMismatched = 0;

    // Reference classification derived from exponent/mantissa as plain integers.
    function automatic void refPrep(input logic [63:0] d, input logic [1:0] fmt,
                                    output logic [63:0] pd, output logic [64:0] ext,
                                    output logic [9:0] cls);
        int unsigned     expo;
        int unsigned     expMax;
        longint unsigned man;
        longint unsigned quietBit;
        longint unsigned mag;
        logic            s;
        int              idx;
        pd = d;
        if (fmt == 2'd0 && d[63:32] != 32'hFFFFFFFF) pd = 64'h000000007FC00000;
        if (fmt == 2'd0) begin
            s = pd[31]; expo = pd[30:23]; expMax = 255;
            man = pd[22:0]; quietBit = 64'h1 << 22; mag = pd[30:0];
        end else begin
            s = pd[63]; expo = pd[62:52]; expMax = 2047;
            man = pd[51:0]; quietBit = 64'h1 << 51; mag = pd[62:0];
        end
        if (expo == expMax) begin
            if (man == 0) idx = s ? 0 : 7;
            else idx = ((man & quietBit) != 0) ? 9 : 8;
        end else if (expo == 0) begin
            if (man == 0) idx = s ? 3 : 4;
            else idx = s ? 2 : 5;
        end else begin
            idx = s ? 1 : 6;
        end
        cls = 10'b1 << idx;
        ext = {s, mag[63:0]};
    endfunction

    function automatic exp_t refEntry(input logic [63:0] a, input logic [63:0] b,
                                      input logic [1:0] f, input logic [2:0] r);
        exp_t e;
        refPrep(a, f, e.data1, e.ext1, e.cls1);
        refPrep(b, f, e.data2, e.ext2, e.cls2);
        e.fmt = f;
        e.rm  = r;
        return e;
    endfunction

    function automatic logic [63:0] randOperand(input logic [1:0] f);
        logic [63:0] d;
        int          k;
        d = {$urandom, $urandom};
        k = $urandom_range(0, 5);
        if (f == 2'd0) begin
            if ($urandom_range(0, 4) != 0) d[63:32] = 32'hFFFFFFFF;
            case (k)
                0: d[30:23] = 8'hFF;
                1: d[30:23] = 8'h00;
                2: begin d[30:23] = 8'hFF; d[22:0] = '0; end
                3: begin d[30:23] = 8'h00; d[22:0] = '0; end
                default: ;
            endcase
        end else begin
            case (k)
                0: d[62:52] = 11'h7FF;
                1: d[62:52] = 11'h000;
                2: begin d[62:52] = 11'h7FF; d[51:0] = '0; end
                3: begin d[62:52] = 11'h000; d[51:0] = '0; end
                default: ;
            endcase
        end
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] f, input logic [2:0] r,
                                 input logic ordy, input logic rs);
        in_valid  = v;
        in_data1  = a;
        in_data2  = b;
        in_fmt    = f;
        in_rm     = r;
        out_ready = ordy;
        rst       = rs;
    endtask

    // Compare every DUT output against the model queue head (zeros when empty).
    task automatic checkAll();
        exp_t h;
        h = '{default: '0};
        if (q.size() != 0) h = q[0];
        checkOutput("count", 65'(count), 65'(q.size()));
        checkOutput("out_valid", 65'(out_valid), 65'(q.size() != 0));
        checkOutput("in_ready", 65'(in_ready), 65'(q.size() < DEPTH));
        checkOutput("out_data1", 65'(out_data1), 65'(h.data1));
        checkOutput("out_data2", 65'(out_data2), 65'(h.data2));
        checkOutput("out_ext1", out_ext1, h.ext1);
        checkOutput("out_ext2", out_ext2, h.ext2);
        checkOutput("out_class1", 65'(out_class1), 65'(h.cls1));
        checkOutput("out_class2", 65'(out_class2), 65'(h.cls2));
        checkOutput("out_fmt", 65'(out_fmt), 65'(h.fmt));
        checkOutput("out_rm", 65'(out_rm), 65'(h.rm));
    endtask

    // Advance one clock: update the model from the inputs present at the edge.
    task automatic stepCycle();
        logic doPush;
        logic doPop;
        exp_t e;
        doPush = in_valid && (q.size() < DEPTH);
        doPop  = out_ready && (q.size() != 0);
        e = refEntry(in_data1, in_data2, in_fmt, in_rm);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
        end else begin
            if (doPop) void'(q.pop_front());
            if (doPush) q.push_back(e);
        end
        checkAll();
    endtask

    initial begin
        vecs[0] = '{64'hC000000000000000, 64'h3FF0000000000000, 2'd1, 64'hC000000000000000,
                    10'h002, 10'h040, {1'b1, 64'h4000000000000000}, {1'b0, 64'h3FF0000000000000}};
        vecs[1] = '{64'h000000003F800000, 64'hFFFFFFFF7F800001, 2'd0, 64'h000000007FC00000,
                    10'h200, 10'h100, {1'b0, 33'b0, 31'h7FC00000}, {1'b0, 33'b0, 31'h7F800001}};
        vecs[2] = '{64'h8000000000000000, 64'h0000000000000001, 2'd1, 64'h8000000000000000,
                    10'h008, 10'h020, {1'b1, 64'h0}, {1'b0, 64'h1}};
        vecs[3] = '{64'h7FF0000000000000, 64'hFFF8000000000000, 2'd2, 64'h7FF0000000000000,
                    10'h080, 10'h200, {1'b0, 64'h7FF0000000000000}, {1'b1, 64'h7FF8000000000000}};
        vecs[4] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFF00000001, 2'd0, 64'hFFFFFFFF80000000,
                    10'h008, 10'h020, {1'b1, 64'h0}, {1'b0, 64'h1}};

        applyStimulus(1'b0, '0, '0, 2'd0, 3'd0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        checkAll();
        applyStimulus(1'b0, '0, '0, 2'd0, 3'd0, 1'b0, 1'b0);
        stepCycle();

        // Directed vectors: push one entry, check it at the head, then drain it.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vecs[i].d1, vecs[i].d2, vecs[i].fmt, 3'(i & 1), 1'b1, 1'b0);
            stepCycle();
            checkOutput("vec_data1", 65'(out_data1), 65'(vecs[i].data1));
            checkOutput("vec_class1", 65'(out_class1), 65'(vecs[i].cls1));
            checkOutput("vec_class2", 65'(out_class2), 65'(vecs[i].cls2));
            checkOutput("vec_ext1", out_ext1, vecs[i].ext1);
            checkOutput("vec_ext2", out_ext2, vecs[i].ext2);
            checkOutput("vec_valid", 65'(out_valid), 65'd1);
            applyStimulus(1'b0, '0, '0, 2'd0, 3'd0, 1'b1, 1'b0);
            stepCycle();
        end

        // Fill under backpressure: A, B accepted, C held until space frees.
        applyStimulus(1'b1, 64'hFFFFFFFF3F800000, 64'hFFFFFFFFBF800000, 2'd0, 3'd0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 64'h4000000000000000, 64'hC008000000000000, 2'd1, 3'd1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("fill_count", 65'(count), 65'd2);
        checkOutput("fill_in_ready", 65'(in_ready), 65'd0);
        applyStimulus(1'b1, 64'h0010000000000000, 64'h7FF4000000000000, 2'd1, 3'd0, 1'b0, 1'b0);
        repeat (2) stepCycle();
        checkOutput("held_count", 65'(count), 65'd2);
        out_ready = 1'b1;
        repeat (2) stepCycle();
        in_valid = 1'b0;
        repeat (2) stepCycle();
        checkOutput("drain_empty", 65'(out_valid), 65'd0);

        // Continuous streaming with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 2'd1, 3'(i), 1'b1, 1'b0);
            stepCycle();
            checkOutput("stream_count", 65'(count), 65'd1);
        end
        in_valid = 1'b0;
        stepCycle();

        // Reset with a full FIFO and a request presented.
        out_ready = 1'b0;
        applyStimulus(1'b1, 64'h3FF0000000000000, 64'h0, 2'd1, 3'd1, 1'b0, 1'b0);
        repeat (2) stepCycle();
        checkOutput("pre_rst_count", 65'(count), 65'd2);
        applyStimulus(1'b1, 64'hBFF0000000000000, 64'h1, 2'd1, 3'd0, 1'b1, 1'b1);
        stepCycle();
        checkOutput("rst_count", 65'(count), 65'd0);
        checkOutput("rst_out_valid", 65'(out_valid), 65'd0);
        checkOutput("rst_in_ready", 65'(in_ready), 65'd1);
        applyStimulus(1'b0, '0, '0, 2'd0, 3'd0, 1'b1, 1'b0);
        stepCycle();

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] f;
            f = 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 3) != 0, randOperand(f), randOperand(f), f,
                          3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                          $urandom_range(0, 60) == 0);
            stepCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
